// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared states, opcodes and phase lengths for the QSPI read scheduler
// Contents: state_t FSM encoding, Fast Read Quad I/O opcode, mode byte,
//           per-phase SCK period counts, phase counter width, phase sequencing helper.

package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_RESP,
    ST_GAP
  } state_t;

  localparam logic [7:0] CMD_FAST_READ_QIO = 8'hEB;
  // Mode byte 0x00: the flash leaves continuous-read mode after every access.
  localparam logic [7:0] MODE_BITS         = 8'h00;

  localparam int CMD_SCK    = 8;  // opcode, one bit per SCK on io[0]
  localparam int ADDR_SCK   = 6;  // 24-bit address, one nibble per SCK
  localparam int MODE_SCK   = 2;  // mode byte, one nibble per SCK
  localparam int DATA_SCK   = 8;  // 32-bit word, one nibble per SCK
  localparam int GAP_CYCLES = 2;  // chip-select deselect time in ACLK cycles

  localparam int CNT_W = 8;

  // Order of the shifting phases on the bus; anything else falls back to idle.
  function automatic state_t next_phase(input state_t s);
    case (s)
      ST_CMD:   return ST_ADDR;
      ST_ADDR:  return ST_MODE;
      ST_MODE:  return ST_DUMMY;
      ST_DUMMY: return ST_DATA;
      ST_DATA:  return ST_RESP;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a last-grant register
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset (port 0 gets priority afterwards)
//   req     in   [1:0] request per port
//   update  in   grant is being consumed this cycle; remember the winner
//   grant   out  [1:0] one-hot grant, combinational from req

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // Index of the port served most recently. Reset to 1 so port 0 wins first.
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (update) begin
      last <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/qspi_read_sched.sv
// rtl/qspi_read_sched.sv - two-port Fast Read Quad I/O (0xEB) scheduler for a serial flash
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   arvalid/arready     [1:0] per-port read-address handshake (0 = fetch, 1 = data)
//   araddr0/araddr1     byte address per port (bits above 23 ignored)
//   rvalid/rready       [1:0] per-port read-data handshake
//   rdata               shared read word, belongs to the port whose rvalid is high
//   sck_o, cs_n_o       flash clock (ACLK/2, idles low), chip select (active low)
//   io_o/io_oe/io_i     quad I/O drive value, per-bit output enable, sampled value

module qspi_read_sched
  import qspi_pkg::*;
#(
  parameter int ADDR_SIZE    = 24,
  parameter int DATA_SIZE    = 32,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [1:0]           arvalid,
  output logic [1:0]           arready,
  input  logic [ADDR_SIZE-1:0] araddr0,
  input  logic [ADDR_SIZE-1:0] araddr1,
  output logic [1:0]           rvalid,
  input  logic [1:0]           rready,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 sck_o,
  output logic                 cs_n_o,
  output logic [3:0]           io_o,
  output logic [3:0]           io_oe,
  input  logic [3:0]           io_i
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;     // remaining SCK periods (or GAP cycles) minus one
  logic             half, half_nxt;   // 0: SCK low half, 1: SCK high half
  logic [23:0]      addr_q;
  logic             gnt_q;            // port owning the transaction in flight
  logic [1:0]       grant;
  logic             take;

  // Counter reload value for each phase; the counter stops at zero.
  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      ST_CMD:   return CNT_W'(CMD_SCK - 1);
      ST_ADDR:  return CNT_W'(ADDR_SCK - 1);
      ST_MODE:  return CNT_W'(MODE_SCK - 1);
      ST_DUMMY: return CNT_W'(DUMMY_CYCLES - 1);
      ST_DATA:  return CNT_W'(DATA_SCK - 1);
      ST_GAP:   return CNT_W'(GAP_CYCLES - 1);
      default:  return '0;
    endcase
  endfunction

  assign take = (state == ST_IDLE) && (|arvalid);

  rr_arb2 u_arb (
    .clk    (ACLK),
    .rst    (ARESET),
    .req    (arvalid),
    .update (take),
    .grant  (grant)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      half   <= 1'b0;
      addr_q <= '0;
      gnt_q  <= 1'b0;
      rdata  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      half  <= half_nxt;
      if (take) begin
        addr_q <= grant[1] ? araddr1[23:0] : araddr0[23:0];
        gnt_q  <= grant[1];
      end
      // io_i is captured on the edge that raises SCK; first nibble ends up in the top bits.
      if (state == ST_DATA && !half) begin
        rdata <= {rdata[DATA_SIZE-5:0], io_i};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    half_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|arvalid) begin
          state_nxt = ST_CMD;
          cnt_nxt   = phase_len(ST_CMD);
        end
      end
      ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA: begin
        half_nxt = ~half;
        // Phase bookkeeping happens on the falling SCK edge so new io_o
        // values appear together with SCK going low.
        if (half) begin
          if (cnt == '0) begin
            state_nxt = next_phase(state);
            cnt_nxt   = phase_len(next_phase(state));
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      ST_RESP: begin
        if (rready[gnt_q]) begin
          state_nxt = ST_GAP;
          cnt_nxt   = phase_len(ST_GAP);
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = phase_len(ST_IDLE);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    io_o  = 4'h0;
    io_oe = 4'h0;
    case (state)
      ST_CMD: begin
        io_oe = 4'b0001;
        io_o  = {3'b000, CMD_FAST_READ_QIO[cnt[2:0]]};
      end
      ST_ADDR: begin
        io_oe = 4'hF;
        io_o  = addr_q[{cnt[2:0], 2'b00} +: 4];
      end
      ST_MODE: begin
        io_oe = 4'hF;
        io_o  = MODE_BITS[{cnt[0], 2'b00} +: 4];
      end
      default: begin
        io_o  = 4'h0;
        io_oe = 4'h0;
      end
    endcase
  end

  assign sck_o   = half;
  assign cs_n_o  = !(state inside {ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY, ST_DATA});
  // Handshake outputs are masked during reset so nothing is accepted or
  // presented in the cycle the reset is being applied.
  assign arready = (state == ST_IDLE && !ARESET) ? grant : 2'b00;
  assign rvalid  = (state == ST_RESP && !ARESET) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
